riscv_core_dpath_vrf_banked: RTL and testbench

//  Parametrised vector register file for the 7-stage RISCV vector datapath.
//  Two combinational LANES-wide read ports and one masked write port; element index wraps modulo VLMAX.

---
 rtl/riscv_vrf_pkg.sv | 29 ++
 rtl/riscv_vrf_clear_fsm.sv | 69 ++++++
 rtl/riscv_core_dpath_vrf_banked.sv | 134 +++++++++++++
 tb/tb_riscv_core_dpath_vrf_banked.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_vrf_pkg.sv
// Shared types and helpers for the banked vector register file.
// Defaults for geometry, clear-FSM state enum, element index wrap.
package riscv_vrf_pkg;

  localparam int VRF_NUM_VREGS = 32;
  localparam int VRF_VLMAX     = 64;
  localparam int VRF_LANES     = 4;
  localparam int VRF_ELEM_W    = 32;

  localparam int VRF_AW    = $clog2(VRF_NUM_VREGS) + 1;
  localparam int VRF_IW    = $clog2(VRF_VLMAX);
  localparam int VRF_BEATS = VRF_VLMAX / VRF_LANES;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } clr_state_e;

  // Element addressed by lane k of an access starting at base.
  function automatic int elem_idx(
    input int base,
    input int k,
    input int vlmax = VRF_VLMAX
  );
    return (base + k) % vlmax;
  endfunction

endpackage

// File: rtl/riscv_vrf_clear_fsm.sv
// Register-clear engine: IDLE -> BUSY (one beat per cycle) -> DONE.
// Ports: i_clk, i_reset_n (sync, active-low), i_clr_req, i_clr_addr;
//   o_clr_busy, o_clr_done, o_clr_we (write-port select),
//   o_clr_sel (register being cleared), o_clr_beat (current beat).
module riscv_vrf_clear_fsm
  import riscv_vrf_pkg::*;
#(
  parameter int BEATS = VRF_BEATS,
  parameter int AW    = VRF_AW,
  localparam int BW   = (BEATS > 1) ? $clog2(BEATS) : 1
) (
  input  logic          i_clk,
  input  logic          i_reset_n,
  input  logic          i_clr_req,
  input  logic [AW-1:0] i_clr_addr,
  output logic          o_clr_busy,
  output logic          o_clr_done,
  output logic          o_clr_we,
  output logic [AW-1:0] o_clr_sel,
  output logic [BW-1:0] o_clr_beat
);

  clr_state_e    r_state;
  clr_state_e    w_next;
  logic [BW-1:0] r_beat;
  logic [AW-1:0] r_addr;

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_state <= IDLE;
      r_beat  <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && i_clr_req) begin
        r_addr <= i_clr_addr;
        r_beat <= '0;
      end else if (r_state == BUSY) begin
        r_beat <= r_beat + 1'b1;
      end
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: if (i_clr_req) w_next = BUSY;
      BUSY: if (r_beat == BW'(BEATS - 1)) w_next = DONE;
      DONE: w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    o_clr_busy = 1'b0;
    o_clr_done = 1'b0;
    unique case (r_state)
      IDLE: ;
      BUSY: o_clr_busy = 1'b1;
      DONE: o_clr_done = 1'b1;
      default: ;
    endcase
  end

  // The engine owns the write port for exactly the BUSY cycles.
  assign o_clr_we   = o_clr_busy;
  assign o_clr_sel  = r_addr;
  assign o_clr_beat = r_beat;

endmodule

// File: rtl/riscv_core_dpath_vrf_banked.sv
// Vector register file: two LANES-wide combinational read ports, one
// masked write port shared with a multi-cycle zero-fill engine.
// Ports: clk, reset_n (sync, active-low);
//   read  raddr0/1, rinter0/1, ridx0/1 -> rdata0/1;
//   write wen, waddr, winter, widx, wmask, wdata, w_rdy;
//   clear clr_req, clr_addr -> clr_busy, clr_done.
// Register NUM_VREGS is the INTER register. Element indices wrap.
// Macro RISCV_VRF_BYPASS_EN adds write->read forwarding.
module riscv_core_dpath_vrf_banked
  import riscv_vrf_pkg::*;
#(
  parameter int NUM_VREGS = VRF_NUM_VREGS,
  parameter int VLMAX     = VRF_VLMAX,
  parameter int LANES     = VRF_LANES,
  parameter int ELEM_W    = VRF_ELEM_W,
  localparam int RW    = $clog2(NUM_VREGS),
  localparam int AW    = RW + 1,
  localparam int IW    = $clog2(VLMAX),
  localparam int DW    = LANES * ELEM_W,
  localparam int BEATS = VLMAX / LANES,
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [RW-1:0]    raddr0,
  input  logic             rinter0,
  input  logic [IW-1:0]    ridx0,
  output logic [DW-1:0]    rdata0,
  input  logic [RW-1:0]    raddr1,
  input  logic             rinter1,
  input  logic [IW-1:0]    ridx1,
  output logic [DW-1:0]    rdata1,
  input  logic             wen,
  output logic             w_rdy,
  input  logic [RW-1:0]    waddr,
  input  logic             winter,
  input  logic [IW-1:0]    widx,
  input  logic [LANES-1:0] wmask,
  input  logic [DW-1:0]    wdata,
  input  logic             clr_req,
  input  logic [AW-1:0]    clr_addr,
  output logic             clr_busy,
  output logic             clr_done
);

  logic [ELEM_W-1:0] r_mem [NUM_VREGS+1][VLMAX];

  logic             w_clr_we;
  logic [AW-1:0]    w_clr_sel;
  logic [BW-1:0]    w_clr_beat;

  logic             w_we;
  logic [AW-1:0]    w_wsel;
  logic [IW-1:0]    w_wbase;
  logic [LANES-1:0] w_wmask;
  logic [DW-1:0]    w_wdata;
  logic [IW-1:0]    w_wk [LANES];
  logic [LANES-1:0] w_wlane;

  logic [AW-1:0]    w_rsel0;
  logic [AW-1:0]    w_rsel1;
  logic [IW-1:0]    w_rk0 [LANES];
  logic [IW-1:0]    w_rk1 [LANES];

  riscv_vrf_clear_fsm #(
    .BEATS (BEATS),
    .AW    (AW)
  ) u_clr (
    .i_clk      (clk),
    .i_reset_n  (reset_n),
    .i_clr_req  (clr_req),
    .i_clr_addr (clr_addr),
    .o_clr_busy (clr_busy),
    .o_clr_done (clr_done),
    .o_clr_we   (w_clr_we),
    .o_clr_sel  (w_clr_sel),
    .o_clr_beat (w_clr_beat)
  );

  assign w_rdy = !clr_busy;

  // Write-port mux: a clear beat wins; external writes only when ready.
  always_comb begin
    w_we = w_clr_we || (wen && w_rdy);
    if (w_clr_we) begin
      w_wsel  = w_clr_sel;
      w_wbase = IW'(int'(w_clr_beat) * LANES);
      w_wmask = '1;
      w_wdata = '0;
    end else begin
      w_wsel  = winter ? AW'(NUM_VREGS) : {1'b0, waddr};
      w_wbase = widx;
      w_wmask = wmask;
      w_wdata = wdata;
    end
    for (int k = 0; k < LANES; k++) begin
      w_wk[k] = IW'(elem_idx(int'(w_wbase), k, VLMAX));
      // Reset suppresses the write; clr_addr beyond INTER is dropped.
      w_wlane[k] = w_we && reset_n && w_wmask[k]
                && (int'(w_wsel) <= NUM_VREGS);
    end
  end

  always_ff @(posedge clk) begin
    for (int k = 0; k < LANES; k++) begin
      if (w_wlane[k]) begin
        r_mem[w_wsel][w_wk[k]] <= w_wdata[k*ELEM_W +: ELEM_W];
      end
    end
  end

  always_comb begin
    w_rsel0 = rinter0 ? AW'(NUM_VREGS) : {1'b0, raddr0};
    w_rsel1 = rinter1 ? AW'(NUM_VREGS) : {1'b0, raddr1};
    rdata0  = '0;
    rdata1  = '0;
    for (int k = 0; k < LANES; k++) begin
      w_rk0[k] = IW'(elem_idx(int'(ridx0), k, VLMAX));
      w_rk1[k] = IW'(elem_idx(int'(ridx1), k, VLMAX));
      rdata0[k*ELEM_W +: ELEM_W] = r_mem[w_rsel0][w_rk0[k]];
      rdata1[k*ELEM_W +: ELEM_W] = r_mem[w_rsel1][w_rk1[k]];
`ifdef RISCV_VRF_BYPASS_EN
      // Lanes of one write hit distinct elements, so at most one matches.
      for (int j = 0; j < LANES; j++) begin
        if (w_wlane[j] && w_wsel == w_rsel0 && w_wk[j] == w_rk0[k])
          rdata0[k*ELEM_W +: ELEM_W] = w_wdata[j*ELEM_W +: ELEM_W];
        if (w_wlane[j] && w_wsel == w_rsel1 && w_wk[j] == w_rk1[k])
          rdata1[k*ELEM_W +: ELEM_W] = w_wdata[j*ELEM_W +: ELEM_W];
      end
`endif
    end
  end

endmodule

// File: tb/tb_riscv_core_dpath_vrf_banked.sv
// Self-checking bench for the banked vector register file.
// Table vectors, clear/reset sequences, randomized traffic vs. model.
module tb_riscv_core_dpath_vrf_banked;

  logic         clk;
  logic         reset_n;
  logic [4:0]   raddr0, raddr1, waddr;
  logic         rinter0, rinter1, winter;
  logic [5:0]   ridx0, ridx1, widx;
  logic [127:0] rdata0, rdata1, wdata;
  logic         wen, w_rdy;
  logic [3:0]   wmask;
  logic         clr_req, clr_busy, clr_done;
  logic [5:0]   clr_addr;

  riscv_core_dpath_vrf_banked dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .raddr0   (raddr0),
    .rinter0  (rinter0),
    .ridx0    (ridx0),
    .rdata0   (rdata0),
    .raddr1   (raddr1),
    .rinter1  (rinter1),
    .ridx1    (ridx1),
    .rdata1   (rdata1),
    .wen      (wen),
    .w_rdy    (w_rdy),
    .waddr    (waddr),
    .winter   (winter),
    .widx     (widx),
    .wmask    (wmask),
    .wdata    (wdata),
    .clr_req  (clr_req),
    .clr_addr (clr_addr),
    .clr_busy (clr_busy),
    .clr_done (clr_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: 33 registers x 64 elements.
  logic [31:0] mdl [33][64];

  typedef struct {
    bit          winter;
    int          waddr;
    int          widx;
    logic [3:0]  wmask;
    logic [127:0] wdata;
    bit          rinter;
    int          raddr;
    int          ridx;
    logic [127:0] exp;
  } vec_t;

  vec_t vt [8];

  function automatic logic [127:0] mdl_rd(input int sel, input int idx);
    logic [127:0] r;
    for (int k = 0; k < 4; k++) r[k*32 +: 32] = mdl[sel][(idx + k) % 64];
    return r;
  endfunction

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic wr(input bit wi, input int wa, input int wx,
                    input logic [3:0] m, input logic [127:0] d);
    @(negedge clk);
    wen = 1'b1; winter = wi; waddr = 5'(wa);
    widx = 6'(wx); wmask = m; wdata = d;
    @(posedge clk);
    #1 wen = 1'b0;
    for (int k = 0; k < 4; k++)
      if (m[k]) mdl[wi ? 32 : wa][(wx + k) % 64] = d[k*32 +: 32];
  endtask

  task automatic rd_chk(input string nm,
                        input bit i0, input int a0, input int x0,
                        input bit i1, input int a1, input int x1);
    @(negedge clk);
    rinter0 = i0; raddr0 = 5'(a0); ridx0 = 6'(x0);
    rinter1 = i1; raddr1 = 5'(a1); ridx1 = 6'(x1);
    #1;
    chk({nm, "/p0"}, rdata0, mdl_rd(i0 ? 32 : a0, x0));
    chk({nm, "/p1"}, rdata1, mdl_rd(i1 ? 32 : a1, x1));
  endtask

  // Starts a clear and samples each cycle until clr_done (bounded).
  // Hooks (sample number, -1 = off): drop_at issues a write while busy,
  // req_at issues a second clr_req while busy and again during DONE,
  // rst_at asserts reset_n and returns with it still low.
  task automatic run_clear(input int addr, input int drop_at,
                           input int req_at, input int rst_at,
                           input bit noise, output int nb,
                           output int nd, output int nbad);
    bit stop;
    @(negedge clk);
    clr_req = 1'b1; clr_addr = 6'(addr);
    @(posedge clk);
    #1 clr_req = 1'b0;
    nb = 0; nd = 0; nbad = 0; stop = 0;
    for (int c = 0; c < 40 && !stop; c++) begin
      @(negedge clk);
      #1;
      wen = 1'b0;
      clr_req = 1'b0;
      if (w_rdy !== !clr_busy) nbad++;
      if (clr_done) begin
        nd++;
        stop = 1;
        if (req_at >= 0) begin
          clr_req = 1'b1; clr_addr = 6'd10;
        end
      end
      if (clr_busy) begin
        if (nb == drop_at) begin
          wen = 1'b1; winter = (addr == 32); waddr = 5'(addr);
          widx = 6'd0; wmask = 4'hF; wdata = {4{32'h55}};
        end else if (noise && $urandom_range(0, 1) == 1) begin
          wen = 1'b1; winter = $urandom_range(0, 1) == 1;
          waddr = 5'($urandom); widx = 6'($urandom);
          wmask = 4'($urandom);
          wdata = {$urandom, $urandom, $urandom, $urandom};
        end
        if (nb == req_at) begin
          clr_req = 1'b1; clr_addr = 6'd10;
        end
        if (nb == rst_at) begin
          reset_n = 1'b0;
          stop = 1;
        end
        nb++;
      end
    end
    if (rst_at < 0) begin
      @(negedge clk);
      clr_req = 1'b0;
      wen = 1'b0;
    end
  endtask

  int nb, nd, nbad, acc, ca;
  int wa, wx, ra0, rx0, ra1, rx1;
  bit wi, ri0, ri1;
  logic [3:0] wm;
  logic [127:0] d, e;

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0; wen = 1'b0; winter = 1'b0; waddr = '0;
    widx = '0; wmask = '0; wdata = '0; clr_req = 1'b0;
    clr_addr = '0; rinter0 = 1'b0; rinter1 = 1'b0;
    raddr0 = '0; raddr1 = '0; ridx0 = '0; ridx1 = '0;

    vt[0] = '{0, 3, 0, 4'hF, {32'd4, 32'd3, 32'd2, 32'd1},
              0, 3, 0, {32'd4, 32'd3, 32'd2, 32'd1}};
    vt[1] = '{0, 3, 0, 4'h0, {4{32'h99}},
              0, 3, 0, {32'd4, 32'd3, 32'd2, 32'd1}};
    vt[2] = '{0, 3, 0, 4'h0, {4{32'h99}},
              0, 4, 0, {32'h403, 32'h402, 32'h401, 32'h400}};
    vt[3] = '{0, 5, 62, 4'hF, {32'hD, 32'hC, 32'hB, 32'hA},
              0, 5, 62, {32'hD, 32'hC, 32'hB, 32'hA}};
    vt[4] = '{0, 5, 0, 4'h0, '0,
              0, 5, 0, {32'h503, 32'h502, 32'hD, 32'hC}};
    vt[5] = '{0, 7, 8, 4'hF, {4{32'hFF}},
              0, 7, 8, {4{32'hFF}}};
    vt[6] = '{0, 7, 8, 4'b0101, {32'd1, 32'd2, 32'd3, 32'd4},
              0, 7, 8, {32'hFF, 32'd2, 32'hFF, 32'd4}};
    vt[7] = '{1, 3, 5, 4'hF, {32'h44, 32'h33, 32'h22, 32'h11},
              1, 3, 5, {32'h44, 32'h33, 32'h22, 32'h11}};

    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    chk("rst_busy", 128'(clr_busy), 128'(0));
    chk("rst_done", 128'(clr_done), 128'(0));
    chk("rst_rdy", 128'(w_rdy), 128'(1));
    reset_n = 1'b1;

    // Known contents everywhere: element e of reg r = (r<<8)|e.
    for (int r = 0; r < 33; r++)
      for (int b = 0; b < 16; b++) begin
        for (int k = 0; k < 4; k++) d[k*32 +: 32] = 32'((r << 8) | (b*4 + k));
        wr(r == 32, r % 32, b * 4, 4'hF, d);
      end

    for (int i = 0; i < 8; i++) begin
      wr(vt[i].winter, vt[i].waddr, vt[i].widx, vt[i].wmask, vt[i].wdata);
      @(negedge clk);
      rinter0 = vt[i].rinter; raddr0 = 5'(vt[i].raddr);
      ridx0 = 6'(vt[i].ridx);
      rinter1 = vt[i].rinter; raddr1 = 5'(vt[i].raddr);
      ridx1 = 6'(vt[i].ridx);
      #1;
      chk($sformatf("vec%0d/p0", i), rdata0, vt[i].exp);
      chk($sformatf("vec%0d/p1", i), rdata1, vt[i].exp);
    end

    // Clear v9 after filling with 0xAA; one write and one clr_req
    // land while busy, another clr_req lands in DONE.
    for (int b = 0; b < 16; b++) wr(0, 9, b * 4, 4'hF, {4{32'hAA}});
    run_clear(9, 3, 8, -1, 0, nb, nd, nbad);
    chk("clr9_busy_cycles", 128'(nb), 128'(16));
    chk("clr9_done_pulses", 128'(nd), 128'(1));
    chk("clr9_rdy_vs_busy", 128'(nbad), 128'(0));
    for (int e2 = 0; e2 < 64; e2++) mdl[9][e2] = '0;
    acc = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      #1;
      if (clr_busy || clr_done) acc++;
    end
    chk("clr9_no_requeue", 128'(acc), 128'(0));
    for (int b = 0; b < 16; b++) begin
      @(negedge clk);
      rinter0 = 0; raddr0 = 5'd9; ridx0 = 6'(b * 4);
      #1;
      chk($sformatf("clr9_zero_b%0d", b), rdata0, 128'(0));
    end
    rd_chk("clr9_v10_kept", 0, 10, 0, 0, 10, 60);

    // Clear INTER.
    run_clear(32, -1, -1, -1, 0, nb, nd, nbad);
    chk("clrI_done_pulses", 128'(nd), 128'(1));
    for (int e2 = 0; e2 < 64; e2++) mdl[32][e2] = '0;
    for (int b = 0; b < 16; b++) begin
      @(negedge clk);
      rinter1 = 1; raddr1 = 5'd3; ridx1 = 6'(b * 4);
      #1;
      chk($sformatf("clrI_zero_b%0d", b), rdata1, 128'(0));
    end
    rd_chk("clrI_v0_kept", 0, 0, 0, 0, 0, 32);

    // Reset lands on beat 5 of a clear of v11.
    run_clear(11, -1, -1, 5, 0, nb, nd, nbad);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk("rstclr_busy", 128'(clr_busy), 128'(0));
    chk("rstclr_rdy", 128'(w_rdy), 128'(1));
    acc = 0;
    for (int c = 0; c < 20; c++) begin
      if (clr_done || clr_busy) acc++;
      @(negedge clk);
      #1;
    end
    chk("rstclr_no_done", 128'(acc), 128'(0));
    for (int e2 = 0; e2 < 20; e2++) mdl[11][e2] = '0;
    for (int b = 0; b < 16; b++)
      rd_chk($sformatf("rstclr_b%0d", b), 0, 11, b * 4, 0, 11, b * 4 + 2);

    // A write coinciding with reset_n=0 is suppressed.
    @(negedge clk);
    reset_n = 1'b0; wen = 1'b1; winter = 0; waddr = 5'd12;
    widx = 6'd0; wmask = 4'hF; wdata = {4{32'h77}};
    @(posedge clk);
    #1 reset_n = 1'b1; wen = 1'b0;
    rd_chk("rstwr_v12", 0, 12, 0, 0, 12, 0);

    // Read of the element being written in the same cycle.
    @(negedge clk);
    wen = 1'b1; winter = 0; waddr = 5'd13; widx = 6'd20;
    wmask = 4'hF; wdata = {32'hB4, 32'hB3, 32'hB2, 32'hB1};
    rinter0 = 0; raddr0 = 5'd13; ridx0 = 6'd20;
    #1;
`ifdef RISCV_VRF_BYPASS_EN
    e = wdata;
`else
    e = mdl_rd(13, 20);
`endif
    chk("rdw_same_cycle", rdata0, e);
    @(posedge clk);
    #1 wen = 1'b0;
    for (int k = 0; k < 4; k++) mdl[13][20 + k] = wdata[k*32 +: 32];
    rd_chk("rdw_after", 0, 13, 20, 0, 13, 18);

    // Random traffic against the model.
    for (int it = 0; it < 200; it++) begin
      if ($urandom_range(0, 24) == 0) begin
        ca = $urandom_range(0, 32);
        run_clear(ca, -1, -1, -1, 1, nb, nd, nbad);
        chk("rnd_clr_done", 128'(nd), 128'(1));
        chk("rnd_clr_busy", 128'(nb), 128'(16));
        for (int e2 = 0; e2 < 64; e2++) mdl[ca][e2] = '0;
      end else begin
        wi = $urandom_range(0, 7) == 0;
        wa = $urandom_range(0, 31);
        wx = $urandom_range(0, 63);
        wm = 4'($urandom);
        d = {$urandom, $urandom, $urandom, $urandom};
        wr(wi, wa, wx, wm, d);
      end
      ri0 = $urandom_range(0, 7) == 0;
      ri1 = $urandom_range(0, 7) == 0;
      ra0 = $urandom_range(0, 31); rx0 = $urandom_range(0, 63);
      ra1 = $urandom_range(0, 31); rx1 = $urandom_range(0, 63);
      if ($urandom_range(0, 1) == 1) begin
        ri0 = wi; ra0 = wa; rx0 = wx;
      end
      rd_chk($sformatf("rnd%0d", it), ri0, ra0, rx0, ri1, ra1, rx1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
